wb_burst_reader: RTL and testbench

- Wishbone master that fetches a contiguous block of 32-bit words from a Wishbone slave (e.g. the BlockRAM controller) using incrementing bursts.
- Pushes fetched words into an internal FIFO that drains through a valid/ready stream.
- Sits between the memory controller and streaming consumers (display, checksum, UART TX).
- The integration wrapper connects its wb_* ports to a wshb_if.master modport.

---
 rtl/wb_burst_reader.sv | 166 ++++++++++++++++
 tb/tb_wb_burst_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader.sv
// Wishbone burst read master: fetches a contiguous word block in incrementing
// bursts sized to fit the output FIFO, then streams the words out via valid/ready.
module wb_burst_reader #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      wb_adr,
  output logic [31:0]      wb_dat_ms,
  input  logic [31:0]      wb_dat_sm,
  output logic             wb_we,
  output logic [3:0]       wb_sel,
  output logic             wb_stb,
  output logic             wb_cyc,
  output logic [2:0]       wb_cti,
  output logic [1:0]       wb_bte,
  input  logic             wb_ack,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  logic [1:0]       state;
  logic [31:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic [BW-1:0]    beats_left;
  logic [BW-1:0]    beats;
  logic             cyc_q;
  logic [2:0]       cti_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  logic [31:0]      rem_w;
  logic [31:0]      free_w;
  logic [31:0]      lim_w;

  assign push = (state == S_BURST) && wb_ack;
  assign pop  = (count != '0) && m_ready;

  // Burst size is fixed at burst start from free FIFO space, so the FIFO cannot overflow.
  always_comb begin
    rem_w  = 32'(remaining);
    free_w = 32'(FIFO_DEPTH) - 32'(count);
    lim_w  = 32'(BURST_LEN);
    if (rem_w < lim_w) lim_w = rem_w;
    if (free_w < lim_w) lim_w = free_w;
    beats = BW'(lim_w);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      beats_left <= '0;
      cyc_q      <= 1'b0;
      cti_q      <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              addr      <= {base_addr[31:2], 2'b00};
              remaining <= len;
              busy_q    <= 1'b1;
              state     <= S_WAIT;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (beats != '0) begin
            beats_left <= beats;
            cyc_q      <= 1'b1;
            cti_q      <= (beats == BW'(1)) ? CTI_EOB : CTI_INCR;
            state      <= S_BURST;
          end
        end
        S_BURST: begin
          if (wb_ack) begin
            addr       <= addr + 32'd4;
            remaining  <= remaining - LEN_W'(1);
            beats_left <= beats_left - BW'(1);
            if (beats_left == BW'(1)) begin
              cyc_q <= 1'b0;
              cti_q <= 3'b000;
              if (remaining == LEN_W'(1)) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state <= S_WAIT;
              end
            end else if (beats_left == BW'(2)) begin
              cti_q <= CTI_EOB;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wb_dat_sm;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wb_adr    = addr;
  assign wb_dat_ms = 32'h0;
  assign wb_we     = 1'b0;
  assign wb_sel    = 4'hF;
  assign wb_stb    = cyc_q;
  assign wb_cyc    = cyc_q;
  assign wb_cti    = cti_q;
  assign wb_bte    = 2'b00;
  assign m_valid   = (count != '0);
  assign m_data    = m_valid ? fifo_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: behavioural slave returning adr>>2, scoreboard of
// expected addresses/data, vector table plus hand sequences for corner cases.
module tb_wb_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        busy, done;
  logic [31:0] wb_adr, wb_dat_ms, wb_dat_sm;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] m_data;
  logic        m_valid, m_ready;

  bit ack_en    = 1'b1;
  bit stray_ack = 1'b0;
  bit ack_rand  = 1'b0;
  int ready_mode = 1;

  always #5 clk = ~clk;

  assign wb_ack    = (wb_cyc & wb_stb & ack_en) | stray_ack;
  assign wb_dat_sm = wb_adr >> 2;

  wb_burst_reader #(.BURST_LEN(8), .FIFO_DEPTH(16), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms),
    .wb_dat_sm(wb_dat_sm), .wb_we(wb_we), .wb_sel(wb_sel), .wb_stb(wb_stb),
    .wb_cyc(wb_cyc), .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_ack(wb_ack),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    bit          rand_ack;
    bit          rand_ready;
    bit          check_cti;
    logic [31:0] exp_first_adr;
    int          exp_bursts;
  } vec_t;

  vec_t vecs [5];

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_adr_q [$];
  logic [31:0] exp_data_q [$];
  logic [2:0]  exp_cti_q [$];
  bit cti_check = 1'b0;
  bit cyc_seen  = 1'b0;
  int cycle = 0, ack_count = 0, eob_count = 0, done_count = 0;
  int done_cycle = 0, last_ack_cycle = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // One clock: drive randomised handshakes after the edge, observe at the falling edge.
  task automatic tick();
    logic [31:0] exp;
    logic [2:0]  exp_cti;
    @(posedge clk);
    #1;
    ack_en = ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    cycle++;
    if (wb_cyc) cyc_seen = 1'b1;
    if (wb_cyc && wb_stb && wb_ack) begin
      ack_count++;
      last_ack_cycle = cycle;
      if (wb_cti == 3'b111) eob_count++;
      if (exp_adr_q.size() == 0) check_output("unexpected_beat", wb_adr, 32'hDEADBEEF);
      else begin
        exp = exp_adr_q.pop_front();
        check_output("wb_adr", wb_adr, exp);
      end
      if (cti_check) begin
        if (exp_cti_q.size() == 0) check_output("unexpected_cti", 32'(wb_cti), 32'hDEADBEEF);
        else begin
          exp_cti = exp_cti_q.pop_front();
          check_output("wb_cti", 32'(wb_cti), 32'(exp_cti));
        end
      end
    end
    if (m_valid && m_ready) begin
      if (exp_data_q.size() == 0) check_output("unexpected_data", m_data, 32'hDEADBEEF);
      else begin
        exp = exp_data_q.pop_front();
        check_output("m_data", m_data, exp);
      end
    end
    if (done) begin
      done_count++;
      done_cycle = cycle;
      check_output("busy_at_done", 32'(busy), 32'h0);
    end
  endtask

  task automatic push_expected(input logic [31:0] first, input int n, input bit with_cti);
    int rem, b;
    for (int i = 0; i < n; i++) begin
      exp_adr_q.push_back(first + 32'(4 * i));
      exp_data_q.push_back((first + 32'(4 * i)) >> 2);
    end
    if (with_cti) begin
      rem = n;
      while (rem > 0) begin
        b = (rem < 8) ? rem : 8;
        for (int j = 0; j < b; j++) exp_cti_q.push_back((j == b - 1) ? 3'b111 : 3'b010);
        rem -= b;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] b, input logic [15:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int done0);
    int n = 0;
    while (done_count == done0 && n < 3000) begin
      tick();
      n++;
    end
    check_output("done_seen", 32'(done_count - done0), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 1;
    while (exp_data_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    tick();
    check_output("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);
    check_output("m_valid_drained", 32'(m_valid), 32'd0);
  endtask

  task automatic run_vector(input vec_t v);
    int ack0, eob0, done0;
    ack_rand   = v.rand_ack;
    ready_mode = v.rand_ready ? 2 : 1;
    cti_check  = v.check_cti;
    push_expected(v.exp_first_adr, int'(v.len), v.check_cti);
    ack0  = ack_count;
    eob0  = eob_count;
    done0 = done_count;
    apply_stimulus(v.base, v.len);
    wait_done(done0);
    check_output("done_latency", 32'(done_cycle), 32'(last_ack_cycle + 1));
    check_output("beat_count", 32'(ack_count - ack0), 32'(v.len));
    if (v.check_cti) check_output("eob_count", 32'(eob_count - eob0), 32'(v.exp_bursts));
    drain();
    ack_rand  = 1'b0;
    cti_check = 1'b0;
  endtask

  initial begin
    int ack0, done0, n;
    vecs[0] = '{32'h0000_0100, 16'd20, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 3};
    vecs[1] = '{32'h0000_0007, 16'd1,  1'b0, 1'b0, 1'b1, 32'h0000_0004, 1};
    vecs[2] = '{32'hFFFF_FFF8, 16'd4,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1};
    vecs[3] = '{32'h0000_0200, 16'd9,  1'b1, 1'b0, 1'b1, 32'h0000_0200, 2};
    vecs[4] = '{32'h0000_003C, 16'd17, 1'b1, 1'b1, 1'b0, 32'h0000_003C, 0};

    rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    m_ready = 1'b1;
    #12;
    check_output("reset_cyc", 32'(wb_cyc), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_done", 32'(done), 32'h0);
    check_output("reset_valid", 32'(m_valid), 32'h0);
    check_output("reset_sel", 32'(wb_sel), 32'hF);
    check_output("reset_cti", 32'(wb_cti), 32'h0);
    check_output("reset_adr", wb_adr, 32'h0);
    check_output("const_we_bte_dat", {wb_dat_ms[29:0], wb_we, wb_bte[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    $display("[TB] zero-length start");
    cyc_seen = 1'b0;
    done0 = done_count;
    apply_stimulus(32'h0000_0040, 16'd0);
    check_output("len0_done", 32'(done), 32'h1);
    check_output("len0_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check_output("len0_done_once", 32'(done_count - done0), 32'd1);
    check_output("len0_no_cyc", 32'(cyc_seen), 32'h0);

    $display("[TB] back-pressure with full FIFO");
    ready_mode = 0;
    push_expected(32'h0000_0400, 40, 1'b0);
    ack0 = ack_count;
    done0 = done_count;
    apply_stimulus(32'h0000_0400, 16'd40);
    for (int i = 0; i < 60; i++) tick();
    check_output("bp_beats_stalled", 32'(ack_count - ack0), 32'd16);
    check_output("bp_cyc_low", 32'(wb_cyc), 32'h0);
    check_output("bp_busy", 32'(busy), 32'h1);
    check_output("bp_valid", 32'(m_valid), 32'h1);
    ready_mode = 1;
    wait_done(done0);
    check_output("bp_beats_total", 32'(ack_count - ack0), 32'd40);
    drain();

    $display("[TB] start while busy is ignored");
    push_expected(32'h0000_0800, 20, 1'b0);
    ack0 = ack_count;
    done0 = done_count;
    apply_stimulus(32'h0000_0800, 16'd20);
    for (int i = 0; i < 5; i++) tick();
    apply_stimulus(32'h0000_0000, 16'd3);
    wait_done(done0);
    check_output("busy_start_beats", 32'(ack_count - ack0), 32'd20);
    drain();

    $display("[TB] stray ack while idle");
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stray_ack = 1'b0;
    tick();
    check_output("stray_valid", 32'(m_valid), 32'h0);
    check_output("stray_busy", 32'(busy), 32'h0);

    $display("[TB] asynchronous reset mid-burst");
    ready_mode = 0;
    push_expected(32'h0000_1000, 8, 1'b0);
    ack0 = ack_count;
    apply_stimulus(32'h0000_1000, 16'd8);
    n = 0;
    while (ack_count - ack0 < 3 && n < 200) begin
      tick();
      n++;
    end
    check_output("rst_acks_before", 32'(ack_count - ack0), 32'd3);
    rst = 1'b0;
    #1;
    check_output("rst_cyc", 32'(wb_cyc), 32'h0);
    check_output("rst_stb", 32'(wb_stb), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_valid", 32'(m_valid), 32'h0);
    exp_adr_q.delete();
    exp_data_q.delete();
    exp_cti_q.delete();
    tick();
    tick();
    rst = 1'b1;
    ready_mode = 1;
    tick();
    run_vector(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
